// File: rtl/count_seq_checker.sv
// Receive-side checker for an up/down counter stream: locks onto the count direction,
// flags out-of-sequence samples and counts errors/wraps. Optional macro: COUNT_DIR_CHECK_EN.
module count_seq_checker #(
    parameter int WIDTH = 4,
    parameter int ERRW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] cnt_in,
`ifdef COUNT_DIR_CHECK_EN
    input  logic             exp_dir,
`endif
    output logic             locked,
    output logic             dir_out,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [ERRW-1:0]  err_count,
    output logic [ERRW-1:0]  wrap_count
);

    typedef enum logic [1:0] {
        EMPTY,
        ACQUIRE,
        TRACK
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
    localparam logic [ERRW-1:0]  SAT = {ERRW{1'b1}};
    localparam logic [ERRW-1:0]  INC = ERRW'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] prev, prev_nxt;
    logic [WIDTH-1:0] delta, exp_val;
    logic             step_up;
    logic             dir_nxt, locked_nxt, err_nxt, wrap_nxt;
    logic [ERRW-1:0]  err_count_nxt, wrap_count_nxt;

    // Direction used to predict the next sample: external when checked, otherwise inferred.
`ifdef COUNT_DIR_CHECK_EN
    assign step_up = exp_dir;
`else
    assign step_up = dir_out;
`endif

    assign delta   = cnt_in - prev;
    assign exp_val = step_up ? (prev + ONE) : (prev - ONE);

    always_comb begin
        state_nxt      = state;
        prev_nxt       = prev;
        dir_nxt        = dir_out;
        err_nxt        = 1'b0;
        wrap_nxt       = 1'b0;
        err_count_nxt  = err_count;
        wrap_count_nxt = wrap_count;

        if (in_valid) begin
            prev_nxt = cnt_in;
            case (state)
                EMPTY: begin
                    state_nxt = ACQUIRE;
                end
                ACQUIRE: begin
`ifdef COUNT_DIR_CHECK_EN
                    if ((exp_dir && delta == ONE) || (!exp_dir && delta == MAX)) begin
                        dir_nxt   = exp_dir;
                        state_nxt = TRACK;
                    end
`else
                    if (delta == ONE) begin
                        dir_nxt   = 1'b1;
                        state_nxt = TRACK;
                    end else if (delta == MAX) begin
                        dir_nxt   = 1'b0;
                        state_nxt = TRACK;
                    end
`endif
                end
                TRACK: begin
`ifdef COUNT_DIR_CHECK_EN
                    dir_nxt = exp_dir;
`endif
                    if (cnt_in == exp_val) begin
                        // An in-sequence step that crosses the top/bottom of the range is a wrap.
                        if (step_up ? (prev == MAX) : (prev == '0)) begin
                            wrap_nxt = 1'b1;
                            if (wrap_count != SAT) begin
                                wrap_count_nxt = wrap_count + INC;
                            end
                        end
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = ACQUIRE;
                        if (err_count != SAT) begin
                            err_count_nxt = err_count + INC;
                        end
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end

        locked_nxt = (state_nxt == TRACK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            prev       <= '0;
            locked     <= 1'b0;
            dir_out    <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
        end else begin
            state      <= state_nxt;
            prev       <= prev_nxt;
            locked     <= locked_nxt;
            dir_out    <= dir_nxt;
            err_pulse  <= err_nxt;
            wrap_pulse <= wrap_nxt;
            err_count  <= err_count_nxt;
            wrap_count <= wrap_count_nxt;
        end
    end

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed, table-driven bench for count_seq_checker; also covers saturation, async reset
// and the COUNT_DIR_CHECK_EN direction-override behaviour when that macro is defined.
module tb_count_seq_checker;

    typedef struct {
        logic       valid;
        logic [3:0] cnt;
        logic       ed;
        int         lk;
        int         dr;
        int         er;
        int         wr;
        int         ec;
        int         wc;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] cnt_in;
`ifdef COUNT_DIR_CHECK_EN
    logic       exp_dir;
`endif
    logic       locked;
    logic       dir_out;
    logic       err_pulse;
    logic       wrap_pulse;
    logic [7:0] err_count;
    logic [7:0] wrap_count;

    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    count_seq_checker #(.WIDTH(4), .ERRW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .cnt_in     (cnt_in),
`ifdef COUNT_DIR_CHECK_EN
        .exp_dir    (exp_dir),
`endif
        .locked     (locked),
        .dir_out    (dir_out),
        .err_pulse  (err_pulse),
        .wrap_pulse (wrap_pulse),
        .err_count  (err_count),
        .wrap_count (wrap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_output(input string tag, input int lk, input int dr, input int er,
                                input int wr, input int ec, input int wc);
        check_val({tag, ".locked"},     int'(locked),     lk);
        check_val({tag, ".dir_out"},    int'(dir_out),    dr);
        check_val({tag, ".err_pulse"},  int'(err_pulse),  er);
        check_val({tag, ".wrap_pulse"}, int'(wrap_pulse), wr);
        check_val({tag, ".err_count"},  int'(err_count),  ec);
        check_val({tag, ".wrap_count"}, int'(wrap_count), wc);
    endtask

    // Inputs change 1ns after a rising edge; outputs are sampled 1ns after the next one.
    task automatic apply_stimulus(input logic v, input logic [3:0] c, input logic ed);
        in_valid = v;
        cnt_in   = c;
`ifdef COUNT_DIR_CHECK_EN
        exp_dir  = ed;
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        cnt_in   = 4'd0;
`ifdef COUNT_DIR_CHECK_EN
        exp_dir  = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic add_vec(input int v, input int c, input int ed, input int lk, input int dr,
                           input int er, input int wr, input int ec, input int wc);
        vec_t t;
        t.valid = v[0];
        t.cnt   = c[3:0];
        t.ed    = ed[0];
        t.lk    = lk;
        t.dr    = dr;
        t.er    = er;
        t.wr    = wr;
        t.ec    = ec;
        t.wc    = wc;
        vecs.push_back(t);
    endtask

    initial begin
        logic [3:0] p;
        n_checks = 0;
        n_fail   = 0;

        //      v  cnt ed  lk dr er wr ec wc
        add_vec(1,  0, 1,  0, 0, 0, 0, 0, 0);
        add_vec(1,  1, 1,  1, 1, 0, 0, 0, 0);
        add_vec(1,  2, 1,  1, 1, 0, 0, 0, 0);
        add_vec(0,  9, 1,  1, 1, 0, 0, 0, 0);
        add_vec(1,  3, 1,  1, 1, 0, 0, 0, 0);
        add_vec(1, 14, 1,  0, 1, 1, 0, 1, 0);
        add_vec(1, 15, 1,  1, 1, 0, 0, 1, 0);
        add_vec(1,  0, 1,  1, 1, 0, 1, 1, 1);
        add_vec(1,  1, 1,  1, 1, 0, 0, 1, 1);
        add_vec(0,  1, 1,  1, 1, 0, 0, 1, 1);
        add_vec(1,  7, 1,  0, 1, 1, 0, 2, 1);
        add_vec(1,  6, 0,  1, 0, 0, 0, 2, 1);
        add_vec(1,  5, 0,  1, 0, 0, 0, 2, 1);
        add_vec(1,  3, 0,  0, 0, 1, 0, 3, 1);
        add_vec(1,  2, 0,  1, 0, 0, 0, 3, 1);
        add_vec(1,  1, 0,  1, 0, 0, 0, 3, 1);
        add_vec(1,  0, 0,  1, 0, 0, 0, 3, 1);
        add_vec(1, 15, 0,  1, 0, 0, 1, 3, 2);
        add_vec(1, 15, 0,  0, 0, 1, 0, 4, 2);
        add_vec(1, 15, 0,  0, 0, 0, 0, 4, 2);
        add_vec(1,  3, 0,  0, 0, 0, 0, 4, 2);
        add_vec(1,  2, 0,  1, 0, 0, 0, 4, 2);

        do_reset();
        check_output("reset", 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].valid, vecs[i].cnt, vecs[i].ed);
            check_output($sformatf("vec%0d", i), vecs[i].lk, vecs[i].dr, vecs[i].er,
                         vecs[i].wr, vecs[i].ec, vecs[i].wc);
        end

        // Reversal while locked up at 7: allowed only when the external direction agrees.
        do_reset();
        apply_stimulus(1'b1, 4'd5, 1'b1);
        apply_stimulus(1'b1, 4'd6, 1'b1);
        apply_stimulus(1'b1, 4'd7, 1'b1);
        check_output("lock_up7", 1, 1, 0, 0, 0, 0);
        apply_stimulus(1'b1, 4'd6, 1'b0);
`ifdef COUNT_DIR_CHECK_EN
        check_output("reverse", 1, 0, 0, 0, 0, 0);
`else
        check_output("reverse", 0, 1, 1, 0, 1, 0);
`endif

        // Saturation: 256 error/relock pairs must leave err_count pinned at 255.
        do_reset();
        apply_stimulus(1'b1, 4'd0, 1'b1);
        apply_stimulus(1'b1, 4'd1, 1'b1);
        p = 4'd1;
        for (int i = 0; i < 256; i++) begin
            p = p + 4'd5;
            apply_stimulus(1'b1, p, 1'b1);
            if (i == 254) begin
                check_val("sat_reach.err_count", int'(err_count), 255);
            end
            if (i == 255) begin
                check_val("sat_hold.err_count", int'(err_count), 255);
                check_val("sat_hold.err_pulse", int'(err_pulse), 1);
            end
            p = p + 4'd1;
            apply_stimulus(1'b1, p, 1'b1);
        end
        check_output("sat_relock", 1, 1, 0, 0, 255, 0);

        // Asynchronous reset mid-TRACK clears outputs without waiting for a clock edge.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_output("async_rst", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // From EMPTY a first sample of 1 must not lock even though prev was cleared to 0.
        apply_stimulus(1'b1, 4'd1, 1'b1);
        check_output("post_rst1", 0, 0, 0, 0, 0, 0);
        apply_stimulus(1'b1, 4'd2, 1'b1);
        check_output("post_rst2", 1, 1, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
